// File: rtl/ram_port_scheduler.sv
// ram_port_scheduler
// ------------------
// Shares one byte-wide synchronous RAM port between an instruction fetch
// requester (ic) and a data load/store requester (dc). Words are moved one
// byte per cycle, little-endian. The RAM returns read data one cycle after
// the address is presented.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   en                  ready; when low, all state and outputs hold
//   ic_en_i, ic_pc_i    instruction word read request and address
//   ic_en_o, ic_ins_o   one-cycle done pulse and instruction word
//   dc_en_i, dc_rwen_i  data request, 1 = write / 0 = read
//   dc_len_i            byte count (1, 2 or 4)
//   dc_adr_i, dc_dat_i  data address and store data
//   dc_en_o, dc_dat_o   one-cycle done pulse and zero-extended load data
//   ram_dat_i           RAM read byte (one cycle after its address)
//   ram_dat_o           RAM write byte
//   ram_adr_o           RAM byte address
//   ram_rwen_o          RAM write strobe
//   iob_full_i          UART buffer full; stalls IO writes (adr[17:16]==2'b11)
//   br_flag             mispredict flush; aborts reads, never stores
//
// Configuration
//   RAM_PORT_RR_EN      defined: round-robin between ic and dc on a tie;
//                       undefined: dc always wins a tie.

module ram_port_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        ic_en_i,
    input  logic [31:0] ic_pc_i,
    output logic        ic_en_o,
    output logic [31:0] ic_ins_o,
    input  logic        dc_en_i,
    input  logic        dc_rwen_i,
    input  logic [2:0]  dc_len_i,
    input  logic [31:0] dc_adr_i,
    input  logic [31:0] dc_dat_i,
    output logic        dc_en_o,
    output logic [31:0] dc_dat_o,
    input  logic [7:0]  ram_dat_i,
    output logic [7:0]  ram_dat_o,
    output logic [31:0] ram_adr_o,
    output logic        ram_rwen_o,
    input  logic        iob_full_i,
    input  logic        br_flag
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IC_RD  = 3'd1,
        DC_RD  = 3'd2,
        DC_WR  = 3'd3,
        IO_GAP = 3'd4
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  len;
    logic [31:0] base;
    logic [31:0] wdat;
    logic [31:0] rbuf;
    logic        is_io;
    logic        cool;
`ifdef RAM_PORT_RR_EN
    logic        last_dc;
`endif

    // Output values for the current cycle, and copies of the last enabled
    // cycle's values so the bus can be frozen while en is low.
    logic [31:0] adr_c, ins_c, ld_c;
    logic [7:0]  dat_c;
    logic        rwen_c, ic_done_c, dc_done_c;
    logic [31:0] adr_h, ins_h, ld_h;
    logic [7:0]  dat_h;
    logic        rwen_h, ic_done_h, dc_done_h;

    logic        dc_io;
    logic        dc_req;
    logic        can_grant;
    logic        pick_dc;
    logic        grant_ic;
    logic        grant_dc;
    logic [5:0]  lane_sh;
    logic [31:0] rd_word;
    logic [7:0]  wr_byte;
    logic [31:0] cur_adr;

    // An IO write waiting on a full UART buffer is simply not eligible, so
    // it neither touches the bus nor blocks an instruction fetch.
    assign dc_io     = (dc_adr_i[17:16] == 2'b11);
    assign dc_req    = dc_en_i && !(dc_rwen_i && dc_io && iob_full_i);
    assign can_grant = (state == IDLE) && !cool && !br_flag;

`ifdef RAM_PORT_RR_EN
    assign pick_dc = dc_req && (!ic_en_i || !last_dc);
`else
    assign pick_dc = dc_req;
`endif

    assign grant_dc = can_grant && pick_dc;
    assign grant_ic = can_grant && ic_en_i && !pick_dc;

    // Byte cnt-1 arrives on ram_dat_i in the cycle where the counter is cnt,
    // so the assembled word merges it into the bytes captured so far.
    assign lane_sh = {cnt - 3'd1, 3'b000};
    assign rd_word = rbuf | ({24'd0, ram_dat_i} << lane_sh);
    assign cur_adr = base + {29'd0, cnt};

    always_comb begin
        wr_byte = wdat[7:0];
        case (cnt[1:0])
            2'd1:    wr_byte = wdat[15:8];
            2'd2:    wr_byte = wdat[23:16];
            2'd3:    wr_byte = wdat[31:24];
            default: wr_byte = wdat[7:0];
        endcase
    end

    // Bus and done outputs. Byte 0 of a granted access goes out in the grant
    // cycle itself, and a read's done pulse carries the last byte straight
    // from ram_dat_i, so these are decoded from state rather than registered.
    always_comb begin
        adr_c     = 32'd0;
        dat_c     = 8'd0;
        rwen_c    = 1'b0;
        ic_done_c = 1'b0;
        dc_done_c = 1'b0;
        ins_c     = 32'd0;
        ld_c      = 32'd0;
        case (state)
            IDLE: begin
                if (grant_ic) begin
                    adr_c = ic_pc_i;
                end else if (grant_dc) begin
                    adr_c = dc_adr_i;
                    if (dc_rwen_i) begin
                        rwen_c    = 1'b1;
                        dat_c     = dc_dat_i[7:0];
                        dc_done_c = (dc_len_i == 3'd1);
                    end
                end
            end
            IC_RD, DC_RD: begin
                if (!br_flag) begin
                    if (cnt < len) begin
                        adr_c = cur_adr;
                    end else begin
                        if (state == IC_RD) begin
                            ic_done_c = 1'b1;
                            ins_c     = rd_word;
                        end else begin
                            dc_done_c = 1'b1;
                            ld_c      = rd_word;
                        end
                    end
                end
            end
            DC_WR: begin
                adr_c     = cur_adr;
                dat_c     = wr_byte;
                rwen_c    = 1'b1;
                dc_done_c = (cnt == len - 3'd1);
            end
            default: begin
                adr_c = 32'd0;
            end
        endcase
    end

    // Sequencer. After any completed access the block spends one cycle in
    // IDLE with cool set so a requester still holding its request is not
    // granted again; IO accesses spend an extra IO_GAP cycle before that.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            len       <= 3'd0;
            base      <= 32'd0;
            wdat      <= 32'd0;
            rbuf      <= 32'd0;
            is_io     <= 1'b0;
            cool      <= 1'b0;
`ifdef RAM_PORT_RR_EN
            last_dc   <= 1'b0;
`endif
            adr_h     <= 32'd0;
            dat_h     <= 8'd0;
            rwen_h    <= 1'b0;
            ic_done_h <= 1'b0;
            dc_done_h <= 1'b0;
            ins_h     <= 32'd0;
            ld_h      <= 32'd0;
        end else if (en) begin
            adr_h     <= adr_c;
            dat_h     <= dat_c;
            rwen_h    <= rwen_c;
            ic_done_h <= ic_done_c;
            dc_done_h <= dc_done_c;
            ins_h     <= ins_c;
            ld_h      <= ld_c;
            case (state)
                IDLE: begin
                    cool <= 1'b0;
                    if (grant_ic) begin
                        state <= IC_RD;
                        base  <= ic_pc_i;
                        len   <= 3'd4;
                        cnt   <= 3'd1;
                        rbuf  <= 32'd0;
                        is_io <= 1'b0;
`ifdef RAM_PORT_RR_EN
                        last_dc <= 1'b0;
`endif
                    end else if (grant_dc) begin
                        base  <= dc_adr_i;
                        len   <= dc_len_i;
                        wdat  <= dc_dat_i;
                        cnt   <= 3'd1;
                        rbuf  <= 32'd0;
                        is_io <= dc_io;
`ifdef RAM_PORT_RR_EN
                        last_dc <= 1'b1;
`endif
                        if (!dc_rwen_i) begin
                            state <= DC_RD;
                        end else if (dc_len_i == 3'd1) begin
                            state <= dc_io ? IO_GAP : IDLE;
                            cool  <= 1'b1;
                        end else begin
                            state <= DC_WR;
                        end
                    end
                end
                IC_RD, DC_RD: begin
                    if (br_flag) begin
                        state <= IDLE;
                    end else if (cnt == len) begin
                        state <= is_io ? IO_GAP : IDLE;
                        cool  <= 1'b1;
                    end else begin
                        rbuf <= rd_word;
                        cnt  <= cnt + 3'd1;
                    end
                end
                DC_WR: begin
                    if (cnt == len - 3'd1) begin
                        state <= is_io ? IO_GAP : IDLE;
                        cool  <= 1'b1;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                IO_GAP: begin
                    state <= IDLE;
                    cool  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Reset forces every output low at once; a low en replays the values of
    // the last enabled cycle.
    assign ram_adr_o  = rst ? (en ? adr_c     : adr_h)     : 32'd0;
    assign ram_dat_o  = rst ? (en ? dat_c     : dat_h)     : 8'd0;
    assign ram_rwen_o = rst ? (en ? rwen_c    : rwen_h)    : 1'b0;
    assign ic_en_o    = rst ? (en ? ic_done_c : ic_done_h) : 1'b0;
    assign dc_en_o    = rst ? (en ? dc_done_c : dc_done_h) : 1'b0;
    assign ic_ins_o   = rst ? (en ? ins_c     : ins_h)     : 32'd0;
    assign dc_dat_o   = rst ? (en ? ld_c      : ld_h)      : 32'd0;

endmodule

// File: tb/tb_ram_port_scheduler.sv
// Directed bench for ram_port_scheduler. Inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge. The RAM model holds
// a fixed instruction word at 0x100..0x103 and a small writable array.

module tb_ram_port_scheduler;

    logic        clk;
    logic        rst;
    logic        en;
    logic        ic_en_i;
    logic [31:0] ic_pc_i;
    logic        ic_en_o;
    logic [31:0] ic_ins_o;
    logic        dc_en_i;
    logic        dc_rwen_i;
    logic [2:0]  dc_len_i;
    logic [31:0] dc_adr_i;
    logic [31:0] dc_dat_i;
    logic        dc_en_o;
    logic [31:0] dc_dat_o;
    logic [7:0]  ram_dat_i;
    logic [7:0]  ram_dat_o;
    logic [31:0] ram_adr_o;
    logic        ram_rwen_o;
    logic        iob_full_i;
    logic        br_flag;

    logic [7:0]  mem [0:65535];

    int numChecks = 0;
    int numFails  = 0;

    logic        flag;
    logic [31:0] expArb;

    ram_port_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ic_en_i    (ic_en_i),
        .ic_pc_i    (ic_pc_i),
        .ic_en_o    (ic_en_o),
        .ic_ins_o   (ic_ins_o),
        .dc_en_i    (dc_en_i),
        .dc_rwen_i  (dc_rwen_i),
        .dc_len_i   (dc_len_i),
        .dc_adr_i   (dc_adr_i),
        .dc_dat_i   (dc_dat_i),
        .dc_en_o    (dc_en_o),
        .dc_dat_o   (dc_dat_o),
        .ram_dat_i  (ram_dat_i),
        .ram_dat_o  (ram_dat_o),
        .ram_adr_o  (ram_adr_o),
        .ram_rwen_o (ram_rwen_o),
        .iob_full_i (iob_full_i),
        .br_flag    (br_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-wide RAM with one cycle read latency.
    always @(posedge clk) begin
        if (ram_rwen_o) mem[ram_adr_o[15:0]] <= ram_dat_o;
        case (ram_adr_o)
            32'h100: ram_dat_i <= 8'h13;
            32'h101: ram_dat_i <= 8'h05;
            32'h102: ram_dat_i <= 8'h00;
            32'h103: ram_dat_i <= 8'h00;
            default: ram_dat_i <= mem[ram_adr_o[15:0]];
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic ic_en, input logic [31:0] pc,
                                 input logic dc_en, input logic rwen, input logic [2:0] len,
                                 input logic [31:0] adr, input logic [31:0] dat);
        ic_en_i   = ic_en;
        ic_pc_i   = pc;
        dc_en_i   = dc_en;
        dc_rwen_i = rwen;
        dc_len_i  = len;
        dc_adr_i  = adr;
        dc_dat_i  = dat;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Called at a sample point; drops each request in the cycle after its
    // done pulse, bounded so a stuck scheduler still reaches the summary.
    task automatic drainRequests();
        logic icd, dcd;
        for (int i = 0; i < 40; i++) begin
            if (!ic_en_i && !dc_en_i) break;
            icd = ic_en_o;
            dcd = dc_en_o;
            tick();
            if (icd) ic_en_i = 1'b0;
            if (dcd) dc_en_i = 1'b0;
            sample();
        end
        checkOutput("drain_pending", {30'd0, ic_en_i, dc_en_i}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        br_flag    = 1'b0;
        iob_full_i = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b0;

        // Reset with requests present: everything stays at zero.
        tick();
        applyStimulus(1, 32'h100, 1, 1, 3'd4, 32'h2000, 32'hFFFFFFFF);
        sample();
        checkOutput("rst_adr",   ram_adr_o, 0);
        checkOutput("rst_rwen",  32'(ram_rwen_o), 0);
        checkOutput("rst_wdat",  32'(ram_dat_o), 0);
        checkOutput("rst_done",  {30'd0, ic_en_o, dc_en_o}, 0);
        checkOutput("rst_state", {29'd0, dut.state}, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        sample();
        tick();
        sample();

        // Instruction read from 0x100.
        tick();
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0);
        flag = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            checkOutput("ic_adr", ram_adr_o, 32'h100 + k);
            if (ic_en_o) flag = 1'b1;
            tick();
        end
        sample();
        checkOutput("ic_early_done", 32'(flag), 0);
        checkOutput("ic_done",  32'(ic_en_o), 1);
        checkOutput("ic_ins",   ic_ins_o, 32'h00000513);
        checkOutput("ic_done_adr", ram_adr_o, 0);
        tick();
        sample();
        checkOutput("cool_no_regrant", ram_adr_o, 0);
        checkOutput("ic_pulse_width", 32'(ic_en_o), 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        sample();

        // Two-byte store.
        tick();
        applyStimulus(0, 0, 1, 1, 3'd2, 32'h2000, 32'hAABBCCDD);
        sample();
        checkOutput("st0_adr",  ram_adr_o, 32'h2000);
        checkOutput("st0_dat",  32'(ram_dat_o), 32'hDD);
        checkOutput("st0_rwen", 32'(ram_rwen_o), 1);
        checkOutput("st0_done", 32'(dc_en_o), 0);
        tick();
        sample();
        checkOutput("st1_adr",  ram_adr_o, 32'h2001);
        checkOutput("st1_dat",  32'(ram_dat_o), 32'hCC);
        checkOutput("st1_rwen", 32'(ram_rwen_o), 1);
        checkOutput("st1_done", 32'(dc_en_o), 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        sample();
        checkOutput("st_after_rwen", 32'(ram_rwen_o), 0);
        checkOutput("st_mem0", 32'(mem[16'h2000]), 32'hDD);
        checkOutput("st_mem1", 32'(mem[16'h2001]), 32'hCC);

        // Arbitration: an ic grant first, then two contests.
        tick();
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0);
        sample();
        drainRequests();
        tick();
        applyStimulus(1, 32'h100, 1, 0, 3'd1, 32'h2000, 0);
        sample();
        checkOutput("arb_first_adr", ram_adr_o, 32'h2000);
        tick();
        sample();
        checkOutput("arb_ld_done", 32'(dc_en_o), 1);
        checkOutput("arb_ld_dat",  dc_dat_o, 32'h000000DD);
        tick();
        dc_en_i = 1'b0;
        sample();
        checkOutput("arb_cool_adr", ram_adr_o, 0);
        tick();
        dc_en_i = 1'b1;
        sample();
`ifdef RAM_PORT_RR_EN
        expArb = 32'h100;
`else
        expArb = 32'h2000;
`endif
        checkOutput("arb_second_adr", ram_adr_o, expArb);
        drainRequests();

        // IO write stalled by a full UART buffer, then the IO gap.
        tick();
        iob_full_i = 1'b1;
        applyStimulus(0, 0, 1, 1, 3'd1, 32'h30000, 32'h41);
        flag = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sample();
            if (ram_rwen_o || ram_adr_o != 32'd0) flag = 1'b1;
            tick();
        end
        iob_full_i = 1'b0;
        sample();
        checkOutput("io_stall_bus", 32'(flag), 0);
        checkOutput("io_rwen", 32'(ram_rwen_o), 1);
        checkOutput("io_adr",  ram_adr_o, 32'h30000);
        checkOutput("io_dat",  32'(ram_dat_o), 32'h41);
        checkOutput("io_done", 32'(dc_en_o), 1);
        tick();
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0);
        sample();
        checkOutput("io_gap_state", {29'd0, dut.state}, 4);
        checkOutput("io_gap_adr", ram_adr_o, 0);
        tick();
        sample();
        checkOutput("gap_idle_state", {29'd0, dut.state}, 0);
        checkOutput("gap_idle_adr", ram_adr_o, 0);
        tick();
        sample();
        checkOutput("post_gap_grant", ram_adr_o, 32'h100);
        drainRequests();

        // A request in a flush cycle is not granted.
        tick();
        br_flag = 1'b1;
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0);
        sample();
        checkOutput("br_idle_ignored", ram_adr_o, 0);
        tick();
        br_flag = 1'b0;
        applyStimulus(0, 0, 1, 0, 3'd4, 32'h100, 0);
        sample();
        checkOutput("ld_flush_grant", ram_adr_o, 32'h100);
        tick();
        sample();
        tick();
        br_flag = 1'b1;
        flag = 1'b0;
        sample();
        if (dc_en_o) flag = 1'b1;
        tick();
        br_flag = 1'b0;
        dc_en_i = 1'b0;
        sample();
        checkOutput("ld_flush_state", {29'd0, dut.state}, 0);
        for (int k = 0; k < 4; k++) begin
            if (dc_en_o) flag = 1'b1;
            tick();
            sample();
        end
        checkOutput("ld_flush_no_done", 32'(flag), 0);

        // The same flush during a four-byte store does not stop it.
        tick();
        applyStimulus(0, 0, 1, 1, 3'd4, 32'h2000, 32'h11223344);
        sample();
        checkOutput("stf0_adr", ram_adr_o, 32'h2000);
        tick();
        sample();
        tick();
        br_flag = 1'b1;
        ic_en_i = 1'b1;
        ic_pc_i = 32'h100;
        sample();
        checkOutput("stf2_adr", ram_adr_o, 32'h2002);
        checkOutput("stf2_dat", 32'(ram_dat_o), 32'h22);
        tick();
        br_flag = 1'b0;
        ic_en_i = 1'b0;
        sample();
        checkOutput("stf3_done", 32'(dc_en_o), 1);
        checkOutput("stf3_adr",  ram_adr_o, 32'h2003);
        checkOutput("stf3_dat",  32'(ram_dat_o), 32'h11);
        tick();
        dc_en_i = 1'b0;
        sample();
        checkOutput("stf_mem3", 32'(mem[16'h2003]), 32'h11);

        // Reset during an instruction read.
        tick();
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0);
        sample();
        checkOutput("rstmid_grant", ram_adr_o, 32'h100);
        tick();
        rst = 1'b0;
        sample();
        checkOutput("rstmid_adr",   ram_adr_o, 0);
        checkOutput("rstmid_ins",   ic_ins_o, 0);
        checkOutput("rstmid_done",  32'(ic_en_o), 0);
        checkOutput("rstmid_state", {29'd0, dut.state}, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        sample();
        tick();
        rst = 1'b1;
        flag = 1'b0;
        for (int k = 0; k < 6; k++) begin
            sample();
            if (ic_en_o) flag = 1'b1;
            tick();
        end
        checkOutput("rstmid_no_done", 32'(flag), 0);

        // en low for three cycles in the middle of an instruction read.
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0);
        sample();
        checkOutput("fz_adr0", ram_adr_o, 32'h100);
        tick();
        sample();
        checkOutput("fz_adr1", ram_adr_o, 32'h101);
        tick();
        en = 1'b0;
        sample();
        checkOutput("fz_hold_a", ram_adr_o, 32'h101);
        tick();
        sample();
        tick();
        sample();
        checkOutput("fz_hold_b", ram_adr_o, 32'h101);
        checkOutput("fz_no_early_done", 32'(ic_en_o), 0);
        tick();
        en = 1'b1;
        sample();
        checkOutput("fz_adr2", ram_adr_o, 32'h102);
        tick();
        sample();
        checkOutput("fz_adr3", ram_adr_o, 32'h103);
        tick();
        sample();
        checkOutput("fz_done", 32'(ic_en_o), 1);
        checkOutput("fz_ins",  ic_ins_o, 32'h00000513);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        sample();

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
